// File: rtl/accum_pkg.sv
// Shared types and default widths for the accumulator engine.
// The saturating-overflow option is selected by defining ACCUM_SAT_EN.
package accum_pkg;

  localparam int ACCUM_DATA_W = 32;
  localparam int ACCUM_ACC_W  = 32;
  localparam int ACCUM_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_OVFL
  } accum_state_e;

endpackage

// File: rtl/accum_add_sat.sv
// Combinational accumulator adder: adds a zero-extended addend to the
// running sum and reports the carry out of the top bit.
// With ACCUM_SAT_EN defined a carrying add clamps to all-ones;
// otherwise the result wraps modulo 2**ACC_W.
import accum_pkg::*;

module accum_add_sat #(
  parameter int DATA_W = ACCUM_DATA_W,
  parameter int ACC_W  = ACCUM_ACC_W
) (
  input  logic [ACC_W-1:0]  acc_in,
  input  logic [DATA_W-1:0] addend,
  output logic [ACC_W-1:0]  result,
  output logic              carry
);

  logic [ACC_W:0] sum;

  // Widen both operands by one bit so the carry lands in sum[ACC_W].
  always_comb begin
    sum    = {1'b0, acc_in} + {{(ACC_W + 1 - DATA_W){1'b0}}, addend};
    carry  = sum[ACC_W];
`ifdef ACCUM_SAT_EN
    result = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    result = sum[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/accum_engine.sv
// Accumulator engine: running sum, saturating sample counter, sticky
// overflow flag and a one-cycle threshold-crossing pulse, sequenced by a
// three-state FSM (IDLE / RUN / OVFL).
// Overflow handling is selected by ACCUM_SAT_EN (see accum_add_sat).
import accum_pkg::*;

module accum_engine #(
  parameter int DATA_W = ACCUM_DATA_W,
  parameter int ACC_W  = ACCUM_ACC_W,
  parameter int CNT_W  = ACCUM_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data,
  input  logic              enable,
  input  logic              clear,
  input  logic [ACC_W-1:0]  thresh,
  output logic [ACC_W-1:0]  accum,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  output logic              thresh_hit,
  output logic              busy
);

  accum_state_e     state;
  accum_state_e     next_state;
  logic [ACC_W-1:0] add_result;
  logic             add_carry;

  accum_add_sat #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc_in (accum),
    .addend (data),
    .result (add_result),
    .carry  (add_carry)
  );

  // FSM state register; reset drops straight back to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: clear wins over everything, a carrying add parks the FSM in OVFL.
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = ST_IDLE;
    end else if (enable) begin
      case (state)
        ST_IDLE: next_state = add_carry ? ST_OVFL : ST_RUN;
        ST_RUN:  next_state = add_carry ? ST_OVFL : ST_RUN;
        ST_OVFL: next_state = ST_OVFL;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Datapath registers: clear discards any simultaneous add; idle cycles hold and drop the pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accum      <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      thresh_hit <= 1'b0;
    end else if (clear) begin
      accum      <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      thresh_hit <= 1'b0;
    end else if (enable) begin
      accum      <= add_result;
      count      <= (count == {CNT_W{1'b1}}) ? count : count + 1'b1;
      ovf        <= ovf | add_carry;
      thresh_hit <= (accum < thresh) && (add_result >= thresh);
    end else begin
      thresh_hit <= 1'b0;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_accum_engine.sv
// Scoreboard bench for accum_engine: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
// Expected overflow values follow ACCUM_SAT_EN.
module tb_accum_engine;

  typedef struct {
    string       name;
    logic [31:0] acc;
    logic [15:0] cnt;
    logic        ovf;
    logic        hit;
    logic        busy;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [31:0] data;
  logic        enable;
  logic        clear;
  logic [31:0] thresh;
  logic [31:0] accum;
  logic [15:0] count;
  logic        ovf;
  logic        thresh_hit;
  logic        busy;

  exp_t expq[$];
  int   checks;
  int   passes;

  accum_engine dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data       (data),
    .enable     (enable),
    .clear      (clear),
    .thresh     (thresh),
    .accum      (accum),
    .count      (count),
    .ovf        (ovf),
    .thresh_hit (thresh_hit),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input string field,
                     input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s.%s got %h want %h", name, field, got, want);
  endtask

  task automatic checkOutput(input exp_t e);
    cmp(e.name, "accum", accum, e.acc);
    cmp(e.name, "count", {16'h0, count}, {16'h0, e.cnt});
    cmp(e.name, "ovf", {31'h0, ovf}, {31'h0, e.ovf});
    cmp(e.name, "thresh_hit", {31'h0, thresh_hit}, {31'h0, e.hit});
    cmp(e.name, "busy", {31'h0, busy}, {31'h0, e.busy});
  endtask

  task automatic pushExp(input string name, input logic [31:0] a, input logic [15:0] c,
                         input logic o, input logic h, input logic b);
    exp_t e;
    e.name = name; e.acc = a; e.cnt = c; e.ovf = o; e.hit = h; e.busy = b;
    expq.push_back(e);
  endtask

  task automatic applyStimulus(input string name, input logic en, input logic clr,
                               input logic [31:0] d, input logic [31:0] a,
                               input logic [15:0] c, input logic o, input logic h,
                               input logic b);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    enable  = en;
    clear   = clr;
    data    = d;
    pushExp(name, a, c, o, h, b);
  endtask

  task automatic resetDut(input string name);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    enable  = 1'b0;
    clear   = 1'b0;
    pushExp(name, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    checks  = 0;
    passes  = 0;
    reset_n = 1'b0;
    enable  = 1'b0;
    clear   = 1'b0;
    data    = '0;
    thresh  = '0;

    resetDut("por");

    applyStimulus("pre_rst_add", 1, 0, 32'h55, 32'h55, 1, 0, 0, 1);
    resetDut("mid_reset");
    applyStimulus("post_rst_idle", 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);

    applyStimulus("add5", 1, 0, 32'd5, 32'd5,  1, 0, 0, 1);
    applyStimulus("add7", 1, 0, 32'd7, 32'd12, 2, 0, 0, 1);
    applyStimulus("add9", 1, 0, 32'd9, 32'd21, 3, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      applyStimulus($sformatf("hold%0d", i), 0, 0, 32'hDEAD, 32'd21, 3, 0, 0, 1);

    applyStimulus("clr_a", 0, 1, 32'h0, 32'h0, 0, 0, 0, 0);
    applyStimulus("near_top", 1, 0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1, 0, 0, 1);
`ifdef ACCUM_SAT_EN
    applyStimulus("carry_add", 1, 0, 32'h20, 32'hFFFF_FFFF, 2, 1, 0, 1);
    applyStimulus("ovfl_add",  1, 0, 32'h1,  32'hFFFF_FFFF, 3, 1, 0, 1);
`else
    applyStimulus("carry_add", 1, 0, 32'h20, 32'h0000_0010, 2, 1, 0, 1);
    applyStimulus("ovfl_add",  1, 0, 32'h1,  32'h0000_0011, 3, 1, 0, 1);
`endif
    applyStimulus("ovfl_hold", 0, 0, 32'h0, expq[$].acc, 3, 1, 0, 1);

    applyStimulus("clr_b", 0, 1, 32'h0, 32'h0, 0, 0, 0, 0);
    applyStimulus("add50", 1, 0, 32'd50, 32'd50, 1, 0, 0, 1);
    applyStimulus("clr_en", 1, 1, 32'd100, 32'h0, 0, 0, 0, 0);
    applyStimulus("after_clr", 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);

    thresh = 32'd10;
    applyStimulus("th_add1", 1, 0, 32'd4, 32'd4,  1, 0, 0, 1);
    applyStimulus("th_add2", 1, 0, 32'd4, 32'd8,  2, 0, 0, 1);
    applyStimulus("th_add3", 1, 0, 32'd4, 32'd12, 3, 0, 1, 1);
    applyStimulus("th_add4", 1, 0, 32'd4, 32'd16, 4, 0, 0, 1);
    applyStimulus("th_idle", 0, 0, 32'd4, 32'd16, 4, 0, 0, 1);

    for (int i = 0; i < 20 && expq.size() != 0; i++) @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain pending %0d want 0", expq.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
